id_ex_hazard_reg: RTL
=====================

// Module: id_ex_hazard_reg
// PURPOSE
//  Decode->Execute pipeline register with load-use hazard detection, bubble insertion,
//  branch flush and memory-wait hold. Registers decoded operands/control for the EX stage
//  (feeds the forwarding unit's *_EX inputs) and drives Stall_ID back to PC/IF-ID.
//  Inserts exactly one bubble per load-use pair, since load data is only forwardable from WB.
// PARAMETERS
//  DATA_W  16  operand / immediate width
//  REG_AW  4   register index width (R0 hardwired zero)
//  CTRL_W  8   opaque ALU/branch control bundle width
// PORTS
//  clk               in   1       clock, all state updates on rising edge
//  rst               in   1       synchronous, active-high reset
//  Valid_ID          in   1       decode slot holds a real instruction
//  Rout1_ID/Rout2_ID in   DATA_W  register-file read data
//  rs1_ID/rs2_ID     in   REG_AW  source indices
//  Read_Enable_1_ID  in   1       rs1 used;  Read_Enable_2_ID in 1  rs2 used
//  rd_ID             in   REG_AW  destination index
//  Write_Enable_ID   in   1       instruction writes rd
//  Write_Back_Sel_ID in   1       1 = load (rd gets memory data)
//  Ctrl_ID           in   CTRL_W  control bundle;  Imm_ID in DATA_W immediate
//  Mem_Busy          in   1       data memory not ready: freeze pipeline
//  Flush_EX          in   1       taken branch resolved in EX: kill ID instruction
//  Valid_EX, Rout1_EX, Rout2_EX, rs1_EX, rs2_EX, Read_Enable_1_EX, Read_Enable_2_EX,
//  rd_EX, Write_Enable_EX, Write_Back_Sel_EX, Ctrl_EX, Imm_EX   out  registered copies of *_ID
//  Stall_ID          out  1       combinational: hold PC and IF/ID this cycle
//  Stall_Reason      out  2       registered: 00 run, 01 bubble, 10 mem hold, 11 flush
//  Stall_Count       out  16      cycles with Stall_ID=1, saturating
// BEHAVIOUR
//  - Reset: every registered output = 0 (EX slot is a bubble, Stall_Count=0, Reason=00).
//  - load_use = Valid_EX & Write_Enable_EX & Write_Back_Sel_EX & (rd_EX!=0) & Valid_ID &
//      ((Read_Enable_1_ID & rs1_ID==rd_EX) | (Read_Enable_2_ID & rs2_ID==rd_EX)).
//  - Stall_ID = Mem_Busy | (load_use & ~Flush_EX).
//  - Edge update priority: rst > Mem_Busy > Flush_EX > load_use > load:
//    HOLD   (Mem_Busy): all EX registers keep value; Flush_EX ignored this cycle (branch
//           unit keeps it asserted until Mem_Busy drops); Reason=10.
//    FLUSH  (Flush_EX): EX <= bubble; Reason=11.
//    BUBBLE (load_use): EX <= bubble, ID instruction held by Stall_ID; Reason=01.
//    LOAD   (otherwise): EX <= *_ID; Valid_ID=0 loads a bubble; Reason=00.
//  - Bubble = Valid_EX, Write_Enable_EX, Write_Back_Sel_EX, Read_Enable_1/2_EX = 0, all data,
//    index, Ctrl, Imm fields = 0 (no spurious writes or forwards).
//  - Latency ID->EX: 1 cycle. Load-use adds exactly 1 cycle: after the bubble the load is in
//    WB when the consumer reaches EX, so no second stall (bubble has Valid_EX=0).
//  - rd_EX=0 load never stalls; rs==rd with Read_Enable low never stalls.
//  - Mem_Busy coincident with load_use: hold wins; the bubble is inserted on the first edge
//    with Mem_Busy=0 if the hazard persists.
//  - Stall_Count += 1 on each edge where Stall_ID=1 and rst=0; holds at 16'hFFFF.
//  - rst asserted mid-stall: next edge yields reset state regardless of other inputs.
// TESTING
//  - Reset: rst=1 one edge with Valid_ID=1 -> Valid_EX=0, Stall_Count=0, Reason=00.
//  - Pass-through: Valid_ID=1, Rout1_ID=16'h1234, rd_ID=5, no hazard -> next edge
//    Rout1_EX=16'h1234, rd_EX=5, Valid_EX=1, Stall_ID=0.
//  - Load-use: EX holds load rd=3; ID uses rs2=3 (RE2=1) -> Stall_ID=1, next edge Valid_EX=0,
//    Reason=01; following edge consumer in EX, Stall_ID=0, Stall_Count=1.
//  - No false stall: EX load rd=0 with ID rs1=0, or EX ALU (WBSel=0) rd=3 with ID rs1=3
//    -> Stall_ID=0, consumer enters EX next edge.
//  - Flush vs hazard: load_use and Flush_EX same cycle -> Stall_ID=0, EX bubble, Reason=11.
//  - Mem hold: Mem_Busy=1 for 3 cycles with Flush_EX=1 -> EX unchanged, Stall_Count +3;
//    Mem_Busy drops -> flush applied next edge; force Stall_Count to FFFF -> stays FFFF.

Source files
------------

// File: rtl/id_ex_hazard_reg.sv
// ID->EX pipeline register with load-use bubble insertion, branch flush and memory-wait hold.
// Also produces the combinational stall for PC/IF-ID and a saturating stall-cycle counter.
module id_ex_hazard_reg #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int CTRL_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              Valid_ID_i,
    input  logic [DATA_W-1:0] Rout1_ID_i,
    input  logic [DATA_W-1:0] Rout2_ID_i,
    input  logic [REG_AW-1:0] rs1_ID_i,
    input  logic [REG_AW-1:0] rs2_ID_i,
    input  logic              Read_Enable_1_ID_i,
    input  logic              Read_Enable_2_ID_i,
    input  logic [REG_AW-1:0] rd_ID_i,
    input  logic              Write_Enable_ID_i,
    input  logic              Write_Back_Sel_ID_i,
    input  logic [CTRL_W-1:0] Ctrl_ID_i,
    input  logic [DATA_W-1:0] Imm_ID_i,
    input  logic              Mem_Busy_i,
    input  logic              Flush_EX_i,
    output logic              Valid_EX_o,
    output logic [DATA_W-1:0] Rout1_EX_o,
    output logic [DATA_W-1:0] Rout2_EX_o,
    output logic [REG_AW-1:0] rs1_EX_o,
    output logic [REG_AW-1:0] rs2_EX_o,
    output logic              Read_Enable_1_EX_o,
    output logic              Read_Enable_2_EX_o,
    output logic [REG_AW-1:0] rd_EX_o,
    output logic              Write_Enable_EX_o,
    output logic              Write_Back_Sel_EX_o,
    output logic [CTRL_W-1:0] Ctrl_EX_o,
    output logic [DATA_W-1:0] Imm_EX_o,
    output logic              Stall_ID_o,
    output logic [1:0]        Stall_Reason_o,
    output logic [15:0]       Stall_Count_o
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rout1;
        logic [DATA_W-1:0] rout2;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              re1;
        logic              re2;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              wbs;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] imm;
    } exSlot_t;

    typedef enum logic [1:0] {
        REASON_RUN    = 2'b00,
        REASON_BUBBLE = 2'b01,
        REASON_HOLD   = 2'b10,
        REASON_FLUSH  = 2'b11
    } reason_e;

    exSlot_t exQ, exD, idSlot;
    reason_e reasonQ, reasonD;
    logic [15:0] countQ, countD;
    logic loadUse;

    assign idSlot = '{
        valid: Valid_ID_i,
        rout1: Rout1_ID_i,
        rout2: Rout2_ID_i,
        rs1:   rs1_ID_i,
        rs2:   rs2_ID_i,
        re1:   Read_Enable_1_ID_i,
        re2:   Read_Enable_2_ID_i,
        rd:    rd_ID_i,
        we:    Write_Enable_ID_i,
        wbs:   Write_Back_Sel_ID_i,
        ctrl:  Ctrl_ID_i,
        imm:   Imm_ID_i
    };

    // Load data is only forwardable from WB, so a consumer directly behind a load must wait.
    assign loadUse = exQ.valid & exQ.we & exQ.wbs & (exQ.rd != '0) & Valid_ID_i &
                     ((Read_Enable_1_ID_i & (rs1_ID_i == exQ.rd)) |
                      (Read_Enable_2_ID_i & (rs2_ID_i == exQ.rd)));

    assign Stall_ID_o = Mem_Busy_i | (loadUse & ~Flush_EX_i);

    always_comb begin
        exD     = exQ;
        reasonD = REASON_RUN;
        if (Mem_Busy_i) begin
            reasonD = REASON_HOLD;
        end else if (Flush_EX_i) begin
            exD     = '0;
            reasonD = REASON_FLUSH;
        end else if (loadUse) begin
            exD     = '0;
            reasonD = REASON_BUBBLE;
        end else begin
            exD = Valid_ID_i ? idSlot : '0;
        end
        countD = (Stall_ID_o && (countQ != 16'hFFFF)) ? countQ + 16'd1 : countQ;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exQ     <= '0;
            reasonQ <= REASON_RUN;
            countQ  <= '0;
        end else begin
            exQ     <= exD;
            reasonQ <= reasonD;
            countQ  <= countD;
        end
    end

    assign Valid_EX_o          = exQ.valid;
    assign Rout1_EX_o          = exQ.rout1;
    assign Rout2_EX_o          = exQ.rout2;
    assign rs1_EX_o            = exQ.rs1;
    assign rs2_EX_o            = exQ.rs2;
    assign Read_Enable_1_EX_o  = exQ.re1;
    assign Read_Enable_2_EX_o  = exQ.re2;
    assign rd_EX_o             = exQ.rd;
    assign Write_Enable_EX_o   = exQ.we;
    assign Write_Back_Sel_EX_o = exQ.wbs;
    assign Ctrl_EX_o           = exQ.ctrl;
    assign Imm_EX_o            = exQ.imm;
    assign Stall_Reason_o      = reasonQ;
    assign Stall_Count_o       = countQ;

endmodule
